shared_adder_sched: RTL and testbench
=====================================

Name: shared_adder_sched

Overview:
- Time-multiplexes one pipelined WIDTH-bit adder between NREQ requesters.
- Round-robin arbitration on a valid/ready request interface.
- The result is returned on a common bus, qualified by a one-hot response valid that identifies the owning requester.
- Sits between operand-producing blocks and the shared adder datapath, as the sole owner and sequencer of that adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and sum width in bits.
- PIPE, 2, adder pipeline latency in cycles (1..4).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  grant enable; when low, no new grants are issued, but in-flight operations still drain.
- req_valid  input  NREQ  per-requester operand valid.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing as req_a.
- req_ready  output  NREQ  one-hot grant; the transfer occurs when req_valid[i] && req_ready[i].
- rsp_valid  output  NREQ  one-hot result valid for the owning requester.
- rsp_sum  output  WIDTH  result sum.
- rsp_carry  output  1  carry out of the addition.
- busy  output  1  high while any pipeline stage holds a valid operation.

Behaviour:
- Reset values: rsp_valid=0, rsp_sum=0, rsp_carry=0, busy=0, all pipeline valids=0, rr pointer=0.
  - req_ready is combinational and is therefore 0 whenever rst is high.
- Arbitration:
  - req_ready = rr_grant(req_valid, ptr) when en=1, else 0.
  - The grant is combinational from req_valid, with no combinational path from req_a/req_b.
  - At most one bit of req_ready is high.
  - The first requester at or after ptr, searching upward with wrap, wins.
- Pointer update:
  - On a transfer by requester g, ptr <= (g+1) mod NREQ.
  - With no transfer, ptr holds.
- Throughput and latency:
  - The pipeline never stalls and responses have no backpressure, so one transfer per cycle is possible.
  - A transfer in cycle t produces rsp_valid[g]=1 in cycle t+PIPE, registered, for exactly one cycle.
- Arithmetic:
  - {rsp_carry, rsp_sum} = zero-extended a + zero-extended b, computed at WIDTH+1 bits, unsigned.
  - The sum wraps modulo 2^WIDTH.
- Tagging:
  - Each stage carries a valid bit, an owner tag of $clog2(NREQ) bits, and operands or partial sum.
  - rsp_valid is the decode of the final-stage tag, gated by the final-stage valid.
- Outputs when idle: when the final-stage valid is 0, rsp_valid=0 and rsp_sum/rsp_carry hold their previous value.
- busy is the OR of all stage valids.
- Stage FSM, per stage: EMPTY -> FULL on an incoming transfer; FULL -> EMPTY when there is no new input. No other states exist.
- Boundary conditions:
  - en falls with an operation in flight: that operation completes normally and no new grants are issued.
  - A single requester holding valid continuously is granted every cycle.
  - All requesters valid: grants rotate 0,1,2,3,0,...
  - req_valid deasserted in the same cycle its grant would occur: no transfer, ptr unchanged.
  - rst asserted mid-operation: all in-flight operations are discarded immediately; no rsp_valid appears after rst releases.
  - Operands all ones (2^WIDTH-1 + 2^WIDTH-1): sum = 2^WIDTH-2, carry=1.

Optional Feature:
- Macro: SHARED_ADDER_SAT_EN.
- Defined:
  - An extra input port sat_mode[NREQ] is present; it is sampled with the operands and carried through the pipeline.
  - For an operation with sat_mode set and carry=1, rsp_sum is forced to all ones, and rsp_carry still reports the true carry.
- Undefined: the port is absent and the result is always the wrapping sum.

Decomposition:
- Package shared_adder_pkg holds:
  - localparam default widths;
  - function onehot_decode;
  - typedef stage_t, a packed struct {logic vld; logic [TAGW-1:0] tag; logic [WIDTH:0] acc}, parameterised via the module using it.
- Sub-module rr_arbiter (NREQ parameter):
  - inputs req, ptr, en;
  - outputs one-hot gnt and encoded idx;
  - purely combinational.
- shared_adder_sched instantiates rr_arbiter and owns the pointer and pipeline registers.

Test Plan:
- Reset check: rst pulsed with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, busy=0; after release, ptr=0, so requester 0 is granted first.
- Single op: NREQ=4, WIDTH=8, PIPE=2; req 2 sends a=8'h7F, b=8'h01 at cycle t -> rsp_valid=4'b0100, rsp_sum=8'h80, rsp_carry=0 at t+2.
- Overflow: req 1 sends a=8'hFF, b=8'hFF -> rsp_sum=8'hFE, rsp_carry=1.
  - With SHARED_ADDER_SAT_EN and sat_mode[1]=1 -> rsp_sum=8'hFF, rsp_carry=1.
- Fairness: all four requesters valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; each response arrives 2 cycles after its grant, tagged to the correct owner.
- Drain and enable: issue 2 ops, then drop en -> both responses arrive, busy falls after the last one, no further req_ready while en=0.
- Reset mid-flight: grant at t, rst asserted at t+1 -> no rsp_valid at t+2 or later; busy=0.

Source files
------------

// File: rtl/shared_adder_pkg.sv
// shared_adder_pkg: default sizes, stage state encoding and tag decode helper
// shared by the shared adder scheduler and its arbiter.
package shared_adder_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_PIPE  = 2;
    localparam int MAX_NREQ  = 8;
    localparam int MAX_TAGW  = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_st_e;

    function automatic logic [MAX_NREQ-1:0] onehot_decode(
        input logic [MAX_TAGW-1:0] idx
    );
        logic [MAX_NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/shared_adder_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; first requester at or
// after ptr (searching upward with wrap) wins.
module rr_arbiter
    import shared_adder_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx
);

    logic [IDXW:0] w_pos;

    // Scan from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        w_pos = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, ptr} + (IDXW+1)'(k);
            if (w_pos >= (IDXW+1)'(NREQ)) begin
                w_pos = w_pos - (IDXW+1)'(NREQ);
            end
            if (en && req[w_pos[IDXW-1:0]]) begin
                gnt = NREQ'(onehot_decode(MAX_TAGW'(w_pos[IDXW-1:0])));
                idx = w_pos[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/shared_adder_sched.sv
// shared_adder_sched: round-robin sequencer for one pipelined shared adder.
// Optional saturation per requester when SHARED_ADDER_SAT_EN is defined.
module shared_adder_sched
    import shared_adder_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int PIPE  = DEF_PIPE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
`ifdef SHARED_ADDER_SAT_EN
    input  logic [NREQ-1:0]       sat_mode,
`endif
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic                  busy
);

    localparam int TAGW = $clog2(NREQ);

    typedef struct packed {
        logic            vld;
        logic [TAGW-1:0] tag;
        logic [WIDTH:0]  acc;
    } stage_t;

    logic [TAGW-1:0]  r_ptr;
    logic [TAGW-1:0]  w_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_acc;

    stage_st_e        r_st  [PIPE];
    stage_st_e        w_nst [PIPE];
    logic [TAGW-1:0]  r_tag [PIPE];
    logic [WIDTH:0]   r_acc [PIPE];
    logic [TAGW-1:0]  w_tin [PIPE];
    logic [WIDTH:0]   w_ain [PIPE];
    logic [PIPE-1:0]  w_in_vld;
    stage_t           w_last;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req (req_valid),
        .ptr (r_ptr),
        .en  (en && !rst),
        .gnt (req_ready),
        .idx (w_idx)
    );

    assign w_xfer = |(req_valid & req_ready);
    assign w_a    = req_a[w_idx*WIDTH +: WIDTH];
    assign w_b    = req_b[w_idx*WIDTH +: WIDTH];
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};

    // Saturation is resolved at entry; the true carry always travels along.
`ifdef SHARED_ADDER_SAT_EN
    assign w_acc = (sat_mode[w_idx] && w_sum[WIDTH])
                 ? {1'b1, {WIDTH{1'b1}}} : w_sum;
`else
    assign w_acc = w_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_idx == TAGW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    always_comb begin
        w_in_vld    = '0;
        w_in_vld[0] = w_xfer;
        w_tin[0]    = w_idx;
        w_ain[0]    = w_acc;
        for (int i = 1; i < PIPE; i++) begin
            w_in_vld[i] = (r_st[i-1] == ST_FULL);
            w_tin[i]    = r_tag[i-1];
            w_ain[i]    = r_acc[i-1];
        end
        for (int i = 0; i < PIPE; i++) begin
            w_nst[i] = r_st[i];
            unique case (r_st[i])
                ST_EMPTY: w_nst[i] = w_in_vld[i] ? ST_FULL : ST_EMPTY;
                ST_FULL:  w_nst[i] = w_in_vld[i] ? ST_FULL : ST_EMPTY;
                default:  w_nst[i] = ST_EMPTY;
            endcase
        end
    end

    // Payload only loads with a valid op so the last result holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                r_st[i]  <= ST_EMPTY;
                r_tag[i] <= '0;
                r_acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE; i++) begin
                r_st[i] <= w_nst[i];
                if (w_in_vld[i]) begin
                    r_tag[i] <= w_tin[i];
                    r_acc[i] <= w_ain[i];
                end
            end
        end
    end

    always_comb begin
        w_last.vld = (r_st[PIPE-1] == ST_FULL);
        w_last.tag = r_tag[PIPE-1];
        w_last.acc = r_acc[PIPE-1];
        rsp_valid  = w_last.vld
                   ? NREQ'(onehot_decode(MAX_TAGW'(w_last.tag))) : '0;
        rsp_sum    = w_last.acc[WIDTH-1:0];
        rsp_carry  = w_last.acc[WIDTH];
        busy       = 1'b0;
        for (int i = 0; i < PIPE; i++) begin
            busy = busy | (r_st[i] == ST_FULL);
        end
    end

endmodule

// File: tb/tb_shared_adder_sched.sv
// tb_shared_adder_sched: directed stimulus with a response scoreboard
// checked by an independent monitor on the falling clock edge.
module tb_shared_adder_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int PIPE  = 2;

    localparam logic [31:0] A_F = 32'h04030201;
    localparam logic [31:0] B_F = 32'h40302010;

    typedef struct {
        logic [3:0] v;
        logic [7:0] s;
        logic       c;
        int         due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_sum;
    logic        rsp_carry;
    logic        busy;
`ifdef SHARED_ADDER_SAT_EN
    logic [3:0]  sat_mode;
    localparam logic [7:0] OVF_SUM = 8'hFF;
`else
    localparam logic [7:0] OVF_SUM = 8'hFE;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t e;

    shared_adder_sched #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .PIPE  (PIPE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef SHARED_ADDER_SAT_EN
        .sat_mode  (sat_mode),
`endif
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid !== 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {28'b0, rsp_valid}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", {28'b0, rsp_valid}, {28'b0, e.v});
                chk("rsp_sum", {24'b0, rsp_sum}, {24'b0, e.s});
                chk("rsp_carry", {31'b0, rsp_carry}, {31'b0, e.c});
                chk("rsp_cycle", cyc, e.due);
            end
        end
        if (sb.size() != 0 && sb[0].due < cyc) begin
            chk("rsp_missing", cyc, sb[0].due);
            void'(sb.pop_front());
        end
    end

    task automatic step(input logic [3:0] v, input logic e_in,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] g, input bit exp_rsp,
                        input logic [7:0] es, input logic ec);
        @(posedge clk);
        #1;
        req_valid = v;
        en        = e_in;
        req_a     = a;
        req_b     = b;
        #3;
        chk("grant", {28'b0, req_ready}, {28'b0, g});
        if (exp_rsp) sb.push_back('{v: g, s: es, c: ec, due: cyc + PIPE});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'h0, 1'b1, A_F, B_F, 4'h0, 0, 8'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        req_valid = 4'hF;
        req_a     = A_F;
        req_b     = B_F;
`ifdef SHARED_ADDER_SAT_EN
        sat_mode  = 4'b0010;
`endif
        @(posedge clk);
        #4;
        chk("rst_ready", {28'b0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {28'b0, rsp_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_sum", {23'b0, rsp_carry, rsp_sum}, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        rst       = 1'b0;

        // All requesters valid: rotation starting at 0.
        for (int i = 0; i < 8; i++) begin
            step(4'hF, 1'b1, A_F, B_F, 4'(1 << (i % 4)), 1,
                 8'(8'h11 * (i % 4 + 1)), 1'b0);
        end
        chk("busy_stream", {31'b0, busy}, 32'h1);
        idle(3);
        chk("busy_idle", {31'b0, busy}, 32'h0);

        step(4'b0100, 1'b1, 32'h007F0000, 32'h00010000, 4'b0100, 1, 8'h80, 1'b0);
        idle(1);
        step(4'b0010, 1'b1, 32'h0000FF00, 32'h0000FF00, 4'b0010, 1, OVF_SUM, 1'b1);

        // Single requester held valid is granted every cycle.
        step(4'b0001, 1'b1, 32'h80, 32'h80, 4'b0001, 1, 8'h00, 1'b1);
        step(4'b0001, 1'b1, 32'h01, 32'hFE, 4'b0001, 1, 8'hFF, 1'b0);
        step(4'b0001, 1'b1, 32'h55, 32'hAA, 4'b0001, 1, 8'hFF, 1'b0);

        // Withdrawn request leaves pointer at 1.
        step(4'h0, 1'b1, A_F, B_F, 4'h0, 0, 8'h0, 1'b0);
        step(4'hF, 1'b1, A_F, B_F, 4'b0010, 1, 8'h22, 1'b0);

        // Two ops then enable drops; both drain.
        step(4'hF, 1'b1, A_F, B_F, 4'b0100, 1, 8'h33, 1'b0);
        step(4'hF, 1'b1, A_F, B_F, 4'b1000, 1, 8'h44, 1'b0);
        step(4'hF, 1'b0, A_F, B_F, 4'h0, 0, 8'h0, 1'b0);
        chk("busy_drain1", {31'b0, busy}, 32'h1);
        step(4'hF, 1'b0, A_F, B_F, 4'h0, 0, 8'h0, 1'b0);
        chk("busy_drain2", {31'b0, busy}, 32'h1);
        step(4'hF, 1'b0, A_F, B_F, 4'h0, 0, 8'h0, 1'b0);
        chk("busy_drained", {31'b0, busy}, 32'h0);
        chk("hold_sum", {23'b0, rsp_carry, rsp_sum}, 32'h044);
        step(4'hF, 1'b0, A_F, B_F, 4'h0, 0, 8'h0, 1'b0);

        // Reset one cycle after a grant discards the op.
        step(4'b0001, 1'b1, 32'h11, 32'h22, 4'b0001, 0, 8'h0, 1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 4'h0;
        #3;
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_rsp", {28'b0, rsp_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        chk("sb_empty", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
